// File: rtl/led_pkg.sv
// led_pkg: shared types for the LED blink controller.
//   mode_t - 2-bit channel mode (OFF / ON / BLINK / ONESHOT)
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_t;

endpackage

// File: rtl/led_chan.sv
// led_chan: one LED channel (mode, half-period, counter, led, wrap).
//   clk, rst      - clock, async active-high reset
//   enable        - count enable; low freezes counter/led/mode
//   wr            - load wr_mode / wr_half this cycle (wins over terminal count)
//   wr_mode       - mode to load
//   wr_half       - half-period to load (0 is stored as 1)
//   led           - registered LED drive
//   wrap          - one-cycle pulse on BLINK toggle or ONESHOT expiry
module led_chan
  import led_pkg::*;
#(
  parameter int          CNT_W    = 27,
  parameter int unsigned HALF_DEF = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             wr,
  input  mode_t            wr_mode,
  input  logic [CNT_W-1:0] wr_half,
  output logic             led,
  output logic             wrap
);

  mode_t            mode, mode_n;
  logic [CNT_W-1:0] half, half_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             led_n, wrap_n;
  logic             term;

  // half is never 0, so half-1 cannot underflow and cnt stays below half
  assign term = (cnt == half - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode <= MODE_BLINK;
      half <= CNT_W'(HALF_DEF);
      cnt  <= '0;
      led  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      mode <= mode_n;
      half <= half_n;
      cnt  <= cnt_n;
      led  <= led_n;
      wrap <= wrap_n;
    end
  end

  always_comb begin
    mode_n = mode;
    half_n = half;
    cnt_n  = cnt;
    led_n  = led;
    wrap_n = 1'b0;
    if (wr) begin
      mode_n = wr_mode;
      half_n = (wr_half == '0) ? CNT_W'(1) : wr_half;
      cnt_n  = '0;
      led_n  = (wr_mode != MODE_OFF);
    end else if (enable) begin
      case (mode)
        MODE_OFF: begin
          cnt_n = '0;
          led_n = 1'b0;
        end
        MODE_ON: begin
          cnt_n = '0;
          led_n = 1'b1;
        end
        MODE_BLINK: begin
          if (term) begin
            cnt_n  = '0;
            led_n  = ~led;
            wrap_n = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin // ONESHOT
          if (term) begin
            cnt_n  = '0;
            led_n  = 1'b0;
            mode_n = MODE_OFF;
            wrap_n = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: N_CH independent LED blink channels with a write port.
//   clk, rst   - clock, async active-high reset
//   enable     - global count enable
//   cfg_valid  - write presented; cfg_ready - write can be accepted
//   cfg_ch     - channel index; cfg_mode - mode; cfg_half - half-period
//   cfg_err    - one-cycle pulse after an accepted write to a missing channel
//   led        - per-channel LED drive; wrap - per-channel toggle/expiry pulse
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int          N_CH     = 4,
  parameter int          CNT_W    = 27,
  parameter int unsigned HALF_DEF = 50000000,
  localparam int         CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_err,
  output logic [N_CH-1:0]  led,
  output logic [N_CH-1:0]  wrap
);

  logic acc;
  logic ch_ok;

  // Ready drops combinationally with rst, so a write pending at reset is lost.
  assign cfg_ready = ~rst;
  assign acc       = cfg_valid & cfg_ready;
  // One extra bit so N_CH itself (e.g. 16) is representable in the compare.
  assign ch_ok     = ({1'b0, cfg_ch} < (CH_W+1)'(N_CH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= acc & ~ch_ok;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_chan #(
      .CNT_W    (CNT_W),
      .HALF_DEF (HALF_DEF)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .wr      (acc & ch_ok & (cfg_ch == CH_W'(i))),
      .wr_mode (mode_t'(cfg_mode)),
      .wr_half (cfg_half),
      .led     (led[i]),
      .wrap    (wrap[i])
    );
  end

endmodule
